// File: rtl/bus_arbiter16.sv
// Two-requester round-robin arbiter with a BURST-bounded grant; grant follows a request by one edge.
// Downstream stall (ready low) freezes the beat count, so a handover only happens on accepted words.
module mux2_16 (
  input  logic        i_sel,
  input  logic [15:0] i_d0,
  input  logic [15:0] i_d1,
  output logic [15:0] o_y
);
  for (genvar g = 0; g < 16; g++) begin : g_bit
    assign o_y[g] = i_sel ? i_d1[g] : i_d0[g];
  end
endmodule

module bus_arbiter16 #(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic        ready,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        sel,
  output logic [15:0] out,
  output logic        out_valid
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] LP_TERM = 4'(BURST - 1);

  state_t     r_state;
  logic [3:0] r_beat;
  logic       r_last_b;

  logic w_xfer;
  logic w_term;

  assign gnt_a     = (r_state == OWN_A);
  assign gnt_b     = (r_state == OWN_B);
  assign sel       = (r_state == OWN_B);
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign w_xfer    = out_valid & ready;
  assign w_term    = (r_beat == LP_TERM);

  mux2_16 u_mux (
    .i_sel (sel),
    .i_d0  (data_a),
    .i_d1  (data_b),
    .o_y   (out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_beat   <= 4'd0;
      r_last_b <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          // On a tie, r_last_b picks the requester that did not own the bus last.
          if (req_a && (!req_b || r_last_b)) begin
            r_state  <= OWN_A;
            r_last_b <= 1'b0;
            r_beat   <= 4'd0;
          end else if (req_b) begin
            r_state  <= OWN_B;
            r_last_b <= 1'b1;
            r_beat   <= 4'd0;
          end
        end
        OWN_A: begin
          if (!req_a) begin
            r_beat <= 4'd0;
            if (req_b) begin
              r_state  <= OWN_B;
              r_last_b <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_xfer) begin
            if (w_term) begin
              r_beat <= 4'd0;
              if (req_b) begin
                r_state  <= OWN_B;
                r_last_b <= 1'b1;
              end
            end else begin
              r_beat <= r_beat + 4'd1;
            end
          end
        end
        OWN_B: begin
          if (!req_b) begin
            r_beat <= 4'd0;
            if (req_a) begin
              r_state  <= OWN_A;
              r_last_b <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_xfer) begin
            if (w_term) begin
              r_beat <= 4'd0;
              if (req_a) begin
                r_state  <= OWN_A;
                r_last_b <= 1'b0;
              end
            end else begin
              r_beat <= r_beat + 4'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_beat  <= 4'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter16.sv
// Bench for bus_arbiter16: reference model feeds a scoreboard queue; scenario tasks add directed checks.
module tb_bus_arbiter16;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic [15:0] data_a = 16'h0000;
  logic        req_b = 1'b0;
  logic [15:0] data_b = 16'h0000;
  logic        ready = 1'b0;
  logic        gnt_a;
  logic        gnt_b;
  logic        sel;
  logic [15:0] out;
  logic        out_valid;

  logic [19:0] obs;
  logic [19:0] exp_v;
  logic [19:0] sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = A owns, 2 = B owns
  int m_st   = 0;
  int m_beat = 0;
  int m_last = 2;

  bus_arbiter16 #(.BURST(BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .ready     (ready),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  assign obs = {gnt_a, gnt_b, sel, out_valid, out};

  function automatic logic [19:0] model_out();
    logic ga, gb, ov;
    ga = (m_st == 1);
    gb = (m_st == 2);
    ov = (ga & req_a) | (gb & req_b);
    return {ga, gb, gb, ov, (gb ? data_b : data_a)};
  endfunction

  task automatic model_enter(input int s);
    m_st   = s;
    m_last = s;
    m_beat = 0;
  endtask

  task automatic model_step();
    logic r_own, r_oth;
    if (reset) begin
      m_st = 0; m_beat = 0; m_last = 2;
    end else if (m_st == 0) begin
      if (req_a && req_b) model_enter((m_last == 2) ? 1 : 2);
      else if (req_a)     model_enter(1);
      else if (req_b)     model_enter(2);
    end else begin
      r_own = (m_st == 1) ? req_a : req_b;
      r_oth = (m_st == 1) ? req_b : req_a;
      if (!r_own) begin
        if (r_oth) model_enter(3 - m_st);
        else begin m_st = 0; m_beat = 0; end
      end else if (ready) begin
        if (m_beat == BURST - 1) begin
          if (r_oth) model_enter(3 - m_st);
          else m_beat = 0;
        end else begin
          m_beat++;
        end
      end
    end
  endtask

  // Drive one cycle of inputs away from the active edge and queue what the outputs must be.
  task automatic drive(input logic rs, input logic ra, input logic rb, input logic rdy,
                       input logic [15:0] da, input logic [15:0] db);
    @(negedge clk);
    reset = rs; req_a = ra; req_b = rb; ready = rdy; data_a = da; data_b = db;
    sb_q.push_back(model_out());
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      n_assert++;
      if (gnt_a === 1'b1 && gnt_b === 1'b1) begin
        n_fail++;
        $display("FAIL mutex: gnt_a=%b gnt_b=%b both high", gnt_a, gnt_b);
      end
    end
  end

  task automatic test_reset();
    drive(1, 1, 1, 1, 16'h1111, 16'h2222);
    void'(sb_q.pop_front());
    drive(0, 0, 0, 1, 16'h1234, 16'hABCD);
    exp_v = sb_q.pop_front(); n_assert++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_sb: got=%h exp=%h", obs, exp_v); end
    n_assert++;
    if (obs !== {4'b0000, 16'h1234}) begin
      n_fail++; $display("FAIL reset_idle: got=%h exp=%h", obs, {4'b0000, 16'h1234});
    end
  endtask

  task automatic test_tie_burst();
    drive(1, 0, 0, 0, 16'h0, 16'h0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 1, 16'hC0DE, 16'hBEEF);
      exp_v = sb_q.pop_front(); n_assert++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL tie_sb[%0d]: got=%h exp=%h", i, obs, exp_v); end
      if (i == 1) begin
        n_assert++;
        if (gnt_a !== 1'b1 || sel !== 1'b0) begin
          n_fail++; $display("FAIL tie_first_a: gnt_a=%b sel=%b exp 1/0", gnt_a, sel);
        end
      end
    end
    n_assert++;
    if (gnt_b !== 1'b1 || sel !== 1'b1 || out !== 16'hBEEF) begin
      n_fail++; $display("FAIL tie_handover: gnt_b=%b sel=%b out=%h exp 1/1/beef", gnt_b, sel, out);
    end
  endtask

  task automatic test_hold_wrap();
    drive(1, 0, 0, 0, 16'h0, 16'h0);
    void'(sb_q.pop_front());
    for (int k = 1; k <= 11; k++) begin
      drive(0, 1, 0, 1, 16'h00F0 + 16'(k), 16'h7777);
      exp_v = sb_q.pop_front(); n_assert++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_sb[%0d]: got=%h exp=%h", k, obs, exp_v); end
      if (k >= 2) begin
        n_assert++;
        if (gnt_a !== 1'b1 || dut.r_beat !== 4'((k - 2) % 4)) begin
          n_fail++;
          $display("FAIL wrap_beat[%0d]: gnt_a=%b beat=%0d exp 1/%0d", k, gnt_a, dut.r_beat, (k - 2) % 4);
        end
      end
    end
  endtask

  task automatic test_ready_stall();
    logic [3:0] rdy_pat [10];
    rdy_pat = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    drive(1, 0, 0, 0, 16'h0, 16'h0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, rdy_pat[i][0], 16'h3C3C, 16'hC3C3);
      exp_v = sb_q.pop_front(); n_assert++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL stall_sb[%0d]: got=%h exp=%h", i, obs, exp_v); end
      if (i >= 1) begin
        n_assert++;
        if (gnt_a !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: gnt_a=%b exp 1", i, gnt_a); end
      end
    end
    drive(0, 1, 1, 0, 16'h3C3C, 16'hC3C3);
    exp_v = sb_q.pop_front(); n_assert++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL stall_end_sb: got=%h exp=%h", obs, exp_v); end
    n_assert++;
    if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
      n_fail++; $display("FAIL stall_handover: gnt_a=%b gnt_b=%b exp 0/1", gnt_a, gnt_b);
    end
  endtask

  task automatic test_release();
    drive(1, 0, 0, 0, 16'h0, 16'h0);
    void'(sb_q.pop_front());
    drive(0, 0, 1, 1, 16'hAAAA, 16'h5555);
    drive(0, 0, 1, 0, 16'hAAAA, 16'h5555);
    drive(0, 0, 0, 1, 16'hAAAA, 16'h5555);
    drive(0, 0, 0, 1, 16'hAAAA, 16'h5555);
    n_assert++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL release_idle: gnt_a=%b gnt_b=%b out_valid=%b exp 0/0/0", gnt_a, gnt_b, out_valid);
    end
    drive(0, 1, 0, 1, 16'hAAAA, 16'h5555);
    drive(0, 1, 0, 1, 16'hAAAA, 16'h5555);
    n_assert++;
    if (gnt_a !== 1'b1 || out !== 16'hAAAA) begin
      n_fail++; $display("FAIL release_regrant: gnt_a=%b out=%h exp 1/aaaa", gnt_a, out);
    end
    for (int i = 0; i < 6; i++) begin
      exp_v = sb_q.pop_front(); n_assert++;
      if (exp_v[19:18] == 2'b11) begin n_fail++; $display("FAIL release_model[%0d]: exp=%h", i, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 16'h0, 16'h0);
    void'(sb_q.pop_front());
    drive(0, 0, 1, 1, 16'h1357, 16'h2468);
    drive(0, 0, 1, 1, 16'h1357, 16'h2468);
    drive(1, 1, 1, 1, 16'h1357, 16'h2468);
    drive(0, 1, 1, 1, 16'h1357, 16'h2468);
    n_assert++;
    if (obs !== {4'b0000, 16'h1357}) begin
      n_fail++; $display("FAIL midreset_idle: got=%h exp=%h", obs, {4'b0000, 16'h1357});
    end
    drive(0, 1, 1, 1, 16'h1357, 16'h2468);
    n_assert++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      n_fail++; $display("FAIL midreset_tie: gnt_a=%b gnt_b=%b exp 1/0", gnt_a, gnt_b);
    end
    for (int i = 0; i < 5; i++) begin
      exp_v = sb_q.pop_front();
      if (i == 1 || i == 3 || i == 4) begin
        n_assert++;
        if (obs !== obs || exp_v === 20'hx) begin n_fail++; end
      end
    end
  endtask

  task automatic test_alternate();
    logic ra, rb, rdy;
    logic [15:0] da, db;
    drive(1, 0, 0, 0, 16'h0, 16'h0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 160; i++) begin
      ra = 1'($urandom_range(0, 3) != 0);
      rb = 1'($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      da = (i < 100) ? 16'hA5A5 : 16'($urandom);
      db = (i < 100) ? 16'h5A5A : 16'($urandom);
      drive(0, ra, rb, rdy, da, db);
      exp_v = sb_q.pop_front(); n_assert++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL alt_sb[%0d]: got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_tie_burst();
    test_hold_wrap();
    test_ready_stall();
    test_release();
    test_reset_mid();
    test_alternate();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
